// File: rtl/fft_frame_reader_if.sv
// ============================================================================
// Module      : fft_frame_reader_if
// Description : Frame input and point-stream output bundle of fft_frame_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_frame_reader_if #(
    parameter int DW = 16
);
    logic            fft_valid;
    logic [2*DW-1:0] fft_d0;
    logic [2*DW-1:0] fft_d1;
    logic [2*DW-1:0] fft_d2;
    logic [2*DW-1:0] fft_d3;
    logic [2*DW-1:0] fft_d4;
    logic [2*DW-1:0] fft_d5;
    logic [2*DW-1:0] fft_d6;
    logic [2*DW-1:0] fft_d7;
    logic [2*DW-1:0] fft_d8;
    logic [2*DW-1:0] fft_d9;
    logic [2*DW-1:0] fft_d10;
    logic [2*DW-1:0] fft_d11;
    logic [2*DW-1:0] fft_d12;
    logic [2*DW-1:0] fft_d13;
    logic [2*DW-1:0] fft_d14;
    logic [2*DW-1:0] fft_d15;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_idx;
    logic [DW-1:0]   out_re;
    logic [DW-1:0]   out_im;
    logic            frame_done;
    logic [3:0]      peak_bin;
    logic            overflow;

    modport master (
        output fft_valid,
        output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
        output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        output out_ready,
        input  out_valid, out_idx, out_re, out_im,
        input  frame_done, peak_bin, overflow
    );

    modport slave (
        input  fft_valid,
        input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
        input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
        input  out_ready,
        output out_valid, out_idx, out_re, out_im,
        output frame_done, peak_bin, overflow
    );
endinterface

`default_nettype wire

// File: rtl/fft_frame_reader.sv
// ============================================================================
// Module      : fft_frame_reader
// Description : Two-frame buffer replaying 16-point FFT frames as a point
//               stream; peak-bin search built when FFT_FRAME_READER_PEAK_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_reader #(
    parameter int DW = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fft_frame_reader_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [2*DW-1:0] w_fft_d [16];
    logic [2*DW-1:0] r_mem   [2][16];

    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic [3:0]      r_idx;
    logic [DW-1:0]   r_re;
    logic [DW-1:0]   r_im;
    logic            r_frame_done;
    logic            r_overflow;

    logic            w_start;
    logic            w_xfer;
    logic            w_last;
    logic            w_cap;
    logic            w_drop;

    assign w_fft_d[0]  = bus.fft_d0;
    assign w_fft_d[1]  = bus.fft_d1;
    assign w_fft_d[2]  = bus.fft_d2;
    assign w_fft_d[3]  = bus.fft_d3;
    assign w_fft_d[4]  = bus.fft_d4;
    assign w_fft_d[5]  = bus.fft_d5;
    assign w_fft_d[6]  = bus.fft_d6;
    assign w_fft_d[7]  = bus.fft_d7;
    assign w_fft_d[8]  = bus.fft_d8;
    assign w_fft_d[9]  = bus.fft_d9;
    assign w_fft_d[10] = bus.fft_d10;
    assign w_fft_d[11] = bus.fft_d11;
    assign w_fft_d[12] = bus.fft_d12;
    assign w_fft_d[13] = bus.fft_d13;
    assign w_fft_d[14] = bus.fft_d14;
    assign w_fft_d[15] = bus.fft_d15;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_xfer      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != 2'd0) begin
                    w_state_nxt = S_SEND;
                    w_start     = 1'b1;
                end
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    w_xfer = 1'b1;
                    if (r_idx == 4'd15) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The last transfer frees its slot in the same cycle, so a full buffer can still accept.
    assign w_cap  = bus.fft_valid && ((r_count != 2'd2) || w_last);
    assign w_drop = bus.fft_valid && !w_cap;

    // When full, the write slot equals the slot whose final point is leaving, so overwriting is safe.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            for (int k = 0; k < 16; k++) begin
                r_mem[r_wr_ptr][k] <= w_fft_d[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_idx        <= 4'd0;
            r_re         <= '0;
            r_im         <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            r_overflow   <= w_drop;
            r_count      <= r_count + {1'b0, w_cap} - {1'b0, w_last};
            if (w_cap) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_last) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_start) begin
                r_idx        <= 4'd0;
                {r_re, r_im} <= r_mem[r_rd_ptr][0];
            end else if (w_xfer && !w_last) begin
                r_idx        <= r_idx + 4'd1;
                {r_re, r_im} <= r_mem[r_rd_ptr][r_idx + 4'd1];
            end
        end
    end

    assign bus.out_valid  = (r_state == S_SEND);
    assign bus.out_idx    = r_idx;
    assign bus.out_re     = r_re;
    assign bus.out_im     = r_im;
    assign bus.frame_done = r_frame_done;
    assign bus.overflow   = r_overflow;

`ifdef FFT_FRAME_READER_PEAK_EN
    logic signed [2*DW-1:0] w_re_x;
    logic signed [2*DW-1:0] w_im_x;
    logic signed [2*DW-1:0] w_re_sq;
    logic signed [2*DW-1:0] w_im_sq;
    logic [2*DW:0]          w_mag;
    logic                   w_new_max;
    logic [2*DW:0]          r_max;
    logic [3:0]             r_max_idx;
    logic [3:0]             r_peak;

    assign w_re_x    = {{DW{r_re[DW-1]}}, r_re};
    assign w_im_x    = {{DW{r_im[DW-1]}}, r_im};
    assign w_re_sq   = w_re_x * w_re_x;
    assign w_im_sq   = w_im_x * w_im_x;
    // Both squares are non-negative, so zero extension keeps the full sum.
    assign w_mag     = {1'b0, w_re_sq} + {1'b0, w_im_sq};
    assign w_new_max = (r_idx == 4'd0) || (w_mag > r_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max     <= '0;
            r_max_idx <= 4'd0;
            r_peak    <= 4'd0;
        end else if (w_xfer) begin
            if (w_new_max) begin
                r_max     <= w_mag;
                r_max_idx <= r_idx;
            end
            if (w_last) begin
                r_peak <= w_new_max ? r_idx : r_max_idx;
            end
        end
    end

    assign bus.peak_bin = r_peak;
`else
    assign bus.peak_bin = 4'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_reader.sv
// ============================================================================
// Module      : tb_fft_frame_reader
// Description : Scoreboard bench for fft_frame_reader (stream, peak, overflow).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_frame_reader;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_frame_reader_if #(.DW(DW)) bus();

    fft_frame_reader #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_ovf = 0;

    logic [2*DW-1:0] cur_frame [16];
    logic [35:0]     sb_q [$];
    logic [3:0]      pk_q [$];

    logic            prev_stall = 1'b0;
    logic [35:0]     prev_pt;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_peak();
        longint best = -1;
        int     bi   = 0;
        for (int k = 0; k < 16; k++) begin
            longint re = longint'($signed(cur_frame[k][2*DW-1:DW]));
            longint im = longint'($signed(cur_frame[k][DW-1:0]));
            longint m  = re * re + im * im;
            if (m > best) begin
                best = m;
                bi   = k;
            end
        end
        return 4'(bi);
    endfunction

    task automatic push_expect();
        for (int k = 0; k < 16; k++) sb_q.push_back({4'(k), cur_frame[k]});
`ifdef FFT_FRAME_READER_PEAK_EN
        pk_q.push_back(model_peak());
`else
        pk_q.push_back(4'd0);
`endif
    endtask

    task automatic drive_data();
        bus.fft_d0  = cur_frame[0];  bus.fft_d1  = cur_frame[1];
        bus.fft_d2  = cur_frame[2];  bus.fft_d3  = cur_frame[3];
        bus.fft_d4  = cur_frame[4];  bus.fft_d5  = cur_frame[5];
        bus.fft_d6  = cur_frame[6];  bus.fft_d7  = cur_frame[7];
        bus.fft_d8  = cur_frame[8];  bus.fft_d9  = cur_frame[9];
        bus.fft_d10 = cur_frame[10]; bus.fft_d11 = cur_frame[11];
        bus.fft_d12 = cur_frame[12]; bus.fft_d13 = cur_frame[13];
        bus.fft_d14 = cur_frame[14]; bus.fft_d15 = cur_frame[15];
    endtask

    // Returns 1 ns after the capture edge.
    task automatic send_frame(input bit expect_kept);
        @(posedge clk); #1;
        drive_data();
        bus.fft_valid = 1'b1;
        if (expect_kept) push_expect();
        @(posedge clk); #1;
        bus.fft_valid = 1'b0;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 16; k++) cur_frame[k] = $urandom;
    endtask

    task automatic wait_drain(input bit rand_ready);
        bit done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(posedge clk); #1;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sb_q.size() == 0 && pk_q.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        check_val("drain_timeout", 64'(done), 64'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", 64'(bus.out_valid), 64'd1);
                check_val("stall_hold", 64'({bus.out_idx, bus.out_re, bus.out_im}), 64'(prev_pt));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_pt    = {bus.out_idx, bus.out_re, bus.out_im};
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) check_val("unexpected_point", 64'(prev_pt), 64'h0);
                else                  check_val("point", 64'(prev_pt), 64'(sb_q.pop_front()));
            end
            if (bus.frame_done) begin
                n_done++;
                if (pk_q.size() == 0) check_val("unexpected_done", 64'd1, 64'd0);
                else                  check_val("peak_bin", 64'(bus.peak_bin), 64'(pk_q.pop_front()));
            end
            if (bus.overflow) n_ovf++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int done0;
        bus.fft_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) cur_frame[k] = '0;
        drive_data();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_outs", 64'({bus.out_idx, bus.out_re, bus.out_im, bus.frame_done,
                                   bus.peak_bin, bus.overflow}), 64'd0);
        rst = 1'b0;

        // Single frame, bin k = {16k, -16k}, bin 5 = {0x0400, 0x0300}
        for (int k = 0; k < 16; k++) cur_frame[k] = {16'(k * 16), 16'(-(k * 16))};
        cur_frame[5] = {16'h0400, 16'h0300};
        send_frame(1'b1);
        @(negedge clk);
        check_val("latency_not_yet", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_val("seq_idx", 64'({bus.out_valid, bus.out_idx}), 64'({1'b1, 4'(i)}));
        end
        @(negedge clk);
        check_val("done_after_15", 64'(bus.frame_done), 64'd1);
        wait_drain(1'b0);

        // Tie keeps lower index; most negative real beats max positive
        for (int k = 0; k < 16; k++) cur_frame[k] = '0;
        cur_frame[3] = {16'h0200, 16'h0000};
        cur_frame[9] = {16'h0200, 16'h0000};
        send_frame(1'b1);
        wait_drain(1'b0);
        for (int k = 0; k < 16; k++) cur_frame[k] = '0;
        cur_frame[0]  = {16'h7FFF, 16'h0000};
        cur_frame[12] = {16'h8000, 16'h0000};
        send_frame(1'b1);
        wait_drain(1'b0);

        // Random backpressure
        for (int f = 0; f < 2; f++) begin
            rand_frame();
            send_frame(1'b1);
            wait_drain(1'b1);
        end

        // Overflow: third frame dropped while stalled
        bus.out_ready = 1'b0;
        done0 = n_done;
        rand_frame(); send_frame(1'b1);
        @(negedge clk); check_val("ovf_f1", 64'(bus.overflow), 64'd0);
        rand_frame(); send_frame(1'b1);
        @(negedge clk); check_val("ovf_f2", 64'(bus.overflow), 64'd0);
        rand_frame(); send_frame(1'b0);
        @(negedge clk); check_val("ovf_pulse", 64'(bus.overflow), 64'd1);
        @(negedge clk); check_val("ovf_one_cycle", 64'(bus.overflow), 64'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain(1'b0);
        check_val("ovf_done_cnt", 64'(n_done - done0), 64'd2);
        check_val("ovf_total", 64'(n_ovf), 64'd1);

        // Capture in the same cycle as the freeing bin-15 transfer
        bus.out_ready = 1'b0;
        done0 = n_done;
        rand_frame(); send_frame(1'b1);
        rand_frame(); send_frame(1'b1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_idx == 4'd15) found = 1'b1;
        end
        check_val("simul_found15", 64'(found), 64'd1);
        rand_frame();
        drive_data();
        bus.fft_valid = 1'b1;
        push_expect();
        @(posedge clk); #1;
        bus.fft_valid = 1'b0;
        wait_drain(1'b0);
        check_val("simul_no_ovf", 64'(n_ovf), 64'd1);
        check_val("simul_done_cnt", 64'(n_done - done0), 64'd3);

        // Asynchronous reset mid-drain
        bus.out_ready = 1'b0;
        rand_frame(); send_frame(1'b1);
        rand_frame(); send_frame(1'b1);
        done0 = n_done;
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_idx == 4'd7) found = 1'b1;
        end
        check_val("rst_found7", 64'(found), 64'd1);
        #1;
        rst = 1'b1;
        sb_q.delete();
        pk_q.delete();
        #1;
        check_val("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid_rst_outs", 64'({bus.out_idx, bus.out_re, bus.out_im, bus.frame_done,
                                       bus.peak_bin, bus.overflow}), 64'd0);
        rand_frame();
        @(posedge clk); #1;
        drive_data();
        bus.fft_valid = 1'b1;
        @(posedge clk); #1;
        bus.fft_valid = 1'b0;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_val("post_rst_idle", 64'({bus.out_valid, bus.frame_done, bus.overflow}), 64'd0);
        end
        check_val("rst_no_done", 64'(n_done - done0), 64'd0);
        for (int k = 0; k < 16; k++) cur_frame[k] = '0;
        cur_frame[11] = {16'hFF00, 16'h0123};
        cur_frame[2]  = {16'h0050, 16'hFFB0};
        send_frame(1'b1);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_new_idx0", 64'({bus.out_valid, bus.out_idx}), 64'({1'b1, 4'd0}));
        wait_drain(1'b0);
        check_val("final_done_cnt", 64'(n_done - done0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_frame_reader.md
# fft_frame_reader

- Consumes the 16-point parallel FFT frame that the FAS core presents with `fft_valid` (`fft_d0`…`fft_d15`).
- Buffers up to two frames and replays each one point per cycle on a valid/ready stream for downstream logic or off-chip readout.
- Finds the peak-magnitude bin of each frame, the same bin index FAS reports on `freq`, so the two results can be cross-checked.

## Interface
- `DW`, default 16: width of each real/imag half (fixed-point, signed); input words are 2·DW bits.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `fft_valid`  in  1: one-cycle strobe; all 16 input words are valid this cycle.
- `fft_d0`…`fft_d15`  in  2·DW each: bin k = {real[2·DW-1:DW], imag[DW-1:0]}, two's complement.
- `out_valid`  out  1: a point is presented.
- `out_ready`  in  1: downstream accepts; transfer = `out_valid && out_ready`.
- `out_idx`  out  4: bin index of the presented point.
- `out_re`, `out_im`  out  DW each: real and imaginary halves of the presented point.
- `frame_done`  out  1: one-cycle pulse after bin 15 of a frame transfers.
- `peak_bin`  out  4: peak bin of the last completed frame; holds until the next `frame_done`.
- `overflow`  out  1: one-cycle pulse; an incoming frame was dropped.

## Operation
- **Storage**
  - Two frame slots used as a 2-entry FIFO: write pointer, read pointer, and a 2-bit occupancy count (0..2).
- **Capture**
  - On `fft_valid` with occupancy < 2, all 16 words are written to the write slot and the write pointer toggles.
  - On `fft_valid` with occupancy == 2, the frame is discarded, `overflow` pulses, and the stored frames are untouched.
- **Drain**
  - Read FSM states: IDLE, SEND.
  - IDLE → SEND when occupancy > 0; `out_idx` = 0.
  - In SEND, each transfer increments `out_idx`.
  - The transfer at `out_idx` = 15 frees the slot, toggles the read pointer, and returns to IDLE.
  - If another frame is stored, the FSM goes back to SEND on the following cycle.
- **Stream rule**
  - While `out_valid && !out_ready`, `out_idx`, `out_re` and `out_im` hold stable.
  - `out_valid` never drops without a transfer.
- **Peak search**
  - At each transfer, mag = re² + im², computed as a signed DW×DW product sum, unsigned, 2·DW+1 bits, no truncation.
  - Compared strictly greater-than against the running maximum; ties keep the lower index.
  - The running maximum resets at `out_idx` = 0.
  - On `frame_done`, `peak_bin` ← winning index.
- **Simultaneous events**
  - `fft_valid` in the same cycle as the bin-15 transfer with occupancy == 2: the slot counts as freed, the frame is captured, and there is no overflow.
  - Occupancy updates net (+1 −1 = 0).

## Timing
- Reset values: `out_valid` 0, `out_idx` 0, `out_re` 0, `out_im` 0, `frame_done` 0, `peak_bin` 0, `overflow` 0, occupancy 0, both pointers 0, FSM IDLE.
- Capture at the rising edge where `fft_valid` = 1; `out_valid` rises at the next edge (latency 1 cycle from the capture edge to the first point).
- Throughput: 1 point/cycle with `out_ready` held high, so 16 cycles per frame. Back-to-back stored frames incur one IDLE bubble cycle between frames.
- `frame_done` and the updated `peak_bin` are registered and appear in the cycle after the bin-15 transfer.
- `overflow` is registered and high for exactly the cycle after the dropped `fft_valid` edge.
- Reset asserted mid-drain: all state clears immediately (asynchronous). Stored frames are lost, and no `frame_done` or `overflow` is generated for them.
- `fft_valid` during reset is ignored.

## Configuration
- `FFT_FRAME_READER_PEAK_EN` defined: peak search logic (multipliers, comparator, running max) is built; `peak_bin` behaves as above.
- Macro undefined: peak logic is removed and `peak_bin` is tied to 0.
  - `frame_done` still pulses.
  - Stream and overflow behaviour are identical.

## Test plan
- Single frame, bin k = {k, −k} (×16 scale), bin 5 = {0x0400, 0x0300}, `out_ready` = 1:
  - `out_idx` 0..15 in 16 consecutive cycles starting 1 cycle after capture, data matches input.
  - `frame_done` one cycle later; `peak_bin` = 5.
- Tie: bins 3 and 9 both {0x0200, 0x0000}, all others 0 → `peak_bin` = 3. Bin 12 = {0x8000, 0} (most negative) wins over bin 0 = {0x7FFF, 0}.
- Backpressure: `out_ready` random at 50% → outputs stable across every stall; all 16 points are delivered exactly once and in order.
- Overflow:
  - Three `fft_valid` pulses 2 cycles apart with `out_ready` = 0 → `overflow` pulses once, the cycle after the 3rd pulse.
  - Releasing `out_ready` delivers frames 1 and 2 only; 2 `frame_done` pulses.
- Simultaneous free/capture: occupancy 2, `fft_valid` in the bin-15 transfer cycle → no `overflow`; the new frame drains after the remaining frame.
- Reset at `out_idx` = 7 of frame 1 with frame 2 stored → next cycle all outputs at reset values. A new frame afterwards drains from `out_idx` 0 with a correct `peak_bin`.
